// File: rtl/conv_encoder_pkg.sv
// Shared constants and state type for the K=7 rate-1/2 convolutional code
// (encoder and the matching Viterbi decoder).
package conv_encoder_pkg;

  localparam int unsigned CONV_K     = 7;
  localparam int unsigned CONV_M     = CONV_K - 1;
  localparam int unsigned TAIL_CNT_W = 3;

  localparam logic [CONV_K-1:0] CONV_G0 = 7'o171;
  localparam logic [CONV_K-1:0] CONV_G1 = 7'o133;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/conv_parity.sv
// One generator branch: XOR of the register taps selected by the generator.
module conv_parity #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] v_i,
  input  logic [W-1:0] gen_i,
  output logic         parity_o
);

  always_comb parity_o = ^(v_i & gen_i);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with valid/ready streaming ports, a single
// registered output stage and optional zero-tail trellis termination.
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter int unsigned   K       = CONV_K,
  parameter logic [K-1:0]  G0      = CONV_G0,
  parameter logic [K-1:0]  G1      = CONV_G1,
  parameter bit            TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last
);

  localparam int unsigned M = K - 1;
  localparam logic [TAIL_CNT_W-1:0] TAIL_LAST = TAIL_CNT_W'(M - 1);

  enc_state_e            state_q, state_d;
  logic [M-1:0]          sr_q, sr_d;
  logic [TAIL_CNT_W-1:0] tcnt_q, tcnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            out_pair_q, out_pair_d;
  logic                  out_last_q, out_last_d;

  logic         loadable, in_xfer, tail_step, load, cur_bit, frame_end;
  logic [K-1:0] v;
  logic         p0, p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      tcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_pair_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_pair_q  <= out_pair_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (in_xfer) begin
          if (in_last) state_d = TAIL_EN ? ST_TAIL : ST_IDLE;
          else         state_d = ST_DATA;
        end
      end
      ST_TAIL: if (tail_step && (tcnt_q == TAIL_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // v[K-1] is the incoming bit (delay 0); v[K-2-i] is sr_q[i] (delay i+1).
  always_comb begin
    loadable  = !out_valid_q || out_ready;
    in_ready  = (state_q != ST_TAIL) && loadable;
    in_xfer   = in_valid && in_ready;
    tail_step = (state_q == ST_TAIL) && loadable;
    load      = in_xfer || tail_step;
    cur_bit   = in_xfer ? in_bit : 1'b0;
    frame_end = tail_step ? (tcnt_q == TAIL_LAST) : (in_xfer && in_last && !TAIL_EN);
    v         = '0;
    v[K-1]    = cur_bit;
    for (int unsigned i = 0; i < M; i++) v[K-2-i] = sr_q[i];
  end

  conv_parity #(.W(K)) u_par0 (.v_i(v), .gen_i(G0), .parity_o(p0));
  conv_parity #(.W(K)) u_par1 (.v_i(v), .gen_i(G1), .parity_o(p1));

  always_comb begin
    sr_d        = sr_q;
    tcnt_d      = tcnt_q;
    out_valid_d = out_valid_q;
    out_pair_d  = out_pair_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_pair_d  = {p1, p0};
      out_last_d  = frame_end;
      sr_d        = frame_end ? '0 : {sr_q[M-2:0], cur_bit};
      tcnt_d      = (tail_step && !frame_end) ? tcnt_q + 1'b1 : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pair  = out_pair_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: reference model is a per-frame bit
// history convolved with the generators, expected pairs queued in order.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_bit, in_last;
  logic       out_valid, out_ready, out_last;
  logic [1:0] out_pair;

  always #5 clk = ~clk;

  conv_encoder #(.TAIL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair), .out_last(out_last)
  );

  typedef struct { logic [1:0] pair; logic last; } exp_t;
  exp_t q[$];
  int   hist[7];
  int   checks = 0;
  int   errors = 0;
  logic [6:0] g0 = 7'o171;
  logic [6:0] g1 = 7'o133;
  logic [1:0] imp_tbl[7];
  bit   imp_mode = 1'b0;
  int   imp_idx  = 0;
  int   pops     = 0;
  logic frame_bits[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_bit(input logic b);
    exp_t e;
    int   p0, p1;
    for (int d = 6; d > 0; d--) hist[d] = hist[d-1];
    hist[0] = int'(b);
    p0 = 0;
    p1 = 0;
    for (int d = 0; d < 7; d++) begin
      if (g0[6-d]) p0 ^= hist[d];
      if (g1[6-d]) p1 ^= hist[d];
    end
    e.pair = {p1[0], p0[0]};
    e.last = 1'b0;
    q.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 7; d++) hist[d] = 0;
  endfunction

  function automatic void model_accept(input logic b, input logic lst);
    model_bit(b);
    if (lst) begin
      for (int t = 0; t < 6; t++) model_bit(1'b0);
      q[q.size()-1].last = 1'b1;
      model_clear();
    end
  endfunction

  task automatic cyc(input logic iv, input logic ib, input logic il, input logic ordy,
                     output logic acc);
    logic       exp_rdy, oxfer, ol;
    logic [1:0] op;
    in_valid  = iv;
    in_bit    = ib;
    in_last   = il;
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pair", out_pair, q[0].pair);
      chk("out_last", out_last, q[0].last);
    end
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("in_ready", in_ready, exp_rdy);
    acc   = iv && in_ready;
    oxfer = out_valid && ordy;
    op    = out_pair;
    ol    = out_last;
    @(posedge clk);
    if (oxfer) begin
      if (imp_mode) begin
        chk("impulse_pair", op, imp_tbl[imp_idx]);
        chk("impulse_last", ol, imp_idx == 6);
        imp_idx++;
      end
      if (q.size() != 0) void'(q.pop_front());
      pops++;
    end
    if (acc) model_accept(ib, il);
    @(negedge clk);
  endtask

  task automatic send_frame(input int vpct, input int rpct);
    int   idx, budget;
    logic iv, rdy, acc;
    idx    = 0;
    budget = 0;
    while (idx < frame_bits.size() && budget < 1000) begin
      iv  = ($urandom_range(99) < vpct);
      rdy = ($urandom_range(99) < rpct);
      if (iv) cyc(1'b1, frame_bits[idx], idx == frame_bits.size() - 1, rdy, acc);
      else    cyc(1'b0, 1'($urandom), 1'($urandom), rdy, acc);
      if (acc) idx++;
      budget++;
    end
    if (idx < frame_bits.size()) chk("send_timeout", 8'(idx), 8'(frame_bits.size()));
  endtask

  task automatic drain(input int rpct);
    int   budget;
    logic acc;
    budget = 0;
    while (q.size() != 0 && budget < 400) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), ($urandom_range(99) < rpct), acc);
      budget++;
    end
    if (q.size() != 0) chk("drain_timeout", 8'(q.size()), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic acc;
    imp_tbl[0] = 2'b11; imp_tbl[1] = 2'b01; imp_tbl[2] = 2'b11; imp_tbl[3] = 2'b11;
    imp_tbl[4] = 2'b00; imp_tbl[5] = 2'b10; imp_tbl[6] = 2'b11;
    model_clear();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pair", out_pair, 2'b00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse frame, always ready
    imp_mode = 1'b1; imp_idx = 0;
    frame_bits = {1'b1};
    send_frame(100, 100);
    drain(100);
    chk("impulse_count", 8'(imp_idx), 8'd7);
    imp_mode = 1'b0;

    // All-zero 8-bit frame: 8 data + 6 tail pairs
    pops = 0;
    frame_bits.delete();
    for (int i = 0; i < 8; i++) frame_bits.push_back(1'b0);
    send_frame(100, 100);
    drain(100);
    chk("zero_pairs", 8'(pops), 8'd14);

    // Backpressure for 5 cycles in the middle of the tail
    imp_mode = 1'b1; imp_idx = 0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, acc);
    chk("bp_accept", acc, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, acc);
    drain(100);
    chk("bp_impulse_count", 8'(imp_idx), 8'd7);
    imp_mode = 1'b0;

    // Back-to-back frames {1,1} then {1}
    pops = 0;
    frame_bits = {1'b1, 1'b1};
    send_frame(100, 100);
    frame_bits = {1'b1};
    send_frame(100, 100);
    drain(100);
    chk("b2b_pairs", 8'(pops), 8'd15);

    // Reset while the third tail pair is presented
    pops = 0;
    frame_bits = {1'b1};
    send_frame(100, 100);
    for (int i = 0; i < 20 && pops < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, acc);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_out_pair", out_pair, 2'b00);
    q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imp_mode = 1'b1; imp_idx = 0;
    frame_bits = {1'b1};
    send_frame(100, 100);
    drain(100);
    chk("post_rst_impulse_count", 8'(imp_idx), 8'd7);
    imp_mode = 1'b0;

    // Random frames with random input gaps and output stalls
    for (int f = 0; f < 8; f++) begin
      frame_bits.delete();
      for (int i = 0; i < int'($urandom_range(20, 1)); i++) frame_bits.push_back(1'($urandom));
      send_frame(70, 70);
    end
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
